// File: rtl/ddr_axi_tester.sv
// AXI-subset write/read-back tester for the DDR controller slave port.
// Writes NUM_BURSTS bursts of a seeded counting pattern, reads each back and tallies mismatches.
module ddr_axi_tester #(
    parameter int BA_BITS    = 2,
    parameter int ROW_BITS   = 13,
    parameter int COL_BITS   = 11,
    parameter int DQ_LEVEL   = 1,
    localparam int DW        = 8 << DQ_LEVEL,
    localparam int AW        = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
    parameter int BURST_LEN  = 7,
    parameter int NUM_BURSTS = 4,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter logic [AW-1:0] ADDR_STEP = AW'('h100),
    parameter logic [15:0]   SEED      = 16'hA5C3,
    parameter int TIMEOUT    = 4095
) (
    input  logic          core_clk,
    input  logic          core_rstn_sync,
    input  logic          init_done,
    input  logic          start,
    output logic          awvalid,
    input  logic          awready,
    output logic [AW-1:0] awaddr,
    output logic [7:0]    awlen,
    output logic          wvalid,
    input  logic          wready,
    output logic [DW-1:0] wdata,
    output logic          wlast,
    input  logic          bvalid,
    output logic          bready,
    output logic          arvalid,
    input  logic          arready,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    input  logic          rvalid,
    output logic          rready,
    input  logic [DW-1:0] rdata,
    input  logic          rlast,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE
    } state_t;

    localparam logic [11:0] TO_LIM = 12'(TIMEOUT);
    localparam logic [7:0]  BLEN8  = 8'(BURST_LEN);
    localparam logic [8:0]  BLEN9  = 9'(BURST_LEN);
    localparam logic [15:0] BEATS  = 16'(BURST_LEN + 1);
    localparam logic [16:0] NB17   = 17'(NUM_BURSTS);

    state_t        state, state_nx;
    logic [11:0]   wd_cnt;
    logic [15:0]   bidx;
    logic [15:0]   bbase;       // b*(BURST_LEN+1), first pattern index of the burst
    logic [8:0]    k;
    logic [AW-1:0] cur_addr;
    logic          timeout_r;
    logic          wd_hit;
    logic          k_last;
    logic [15:0]   pat;
    logic [DW-1:0] pat_full;
    logic          go;
    logic          r_fire;
    logic          beat_err;

    assign k_last   = (k == BLEN9);
    assign pat      = (bbase + {7'd0, k}) ^ SEED;
    assign pat_full = {(DW/16){pat}};
    assign go       = start & init_done;

    // Watchdog only arms in states that wait on the slave
    always_comb begin
        wd_hit = 1'b0;
        if (state == S_AW || state == S_W || state == S_B || state == S_AR || state == S_R)
            wd_hit = (wd_cnt == TO_LIM);
    end

    assign awvalid = (state == S_AW) & ~wd_hit;
    assign arvalid = (state == S_AR) & ~wd_hit;
    assign wvalid  = (state == S_W)  & ~wd_hit;
    assign rready  = (state == S_R)  & ~wd_hit;
    // The controller closes a read on bready, so it stays high through R
    assign bready  = ((state == S_B) | (state == S_R)) & ~wd_hit;
    assign awaddr  = cur_addr;
    assign araddr  = cur_addr;
    assign awlen   = awvalid ? BLEN8 : 8'd0;
    assign arlen   = arvalid ? BLEN8 : 8'd0;
    assign wdata   = wvalid ? pat_full : '0;
    assign wlast   = wvalid & k_last;

    assign busy    = (state != S_IDLE) & (state != S_DONE);
    assign done    = (state == S_DONE);
    assign pass    = done & (err_cnt == 16'd0) & ~timeout_r;
    assign timeout = timeout_r;

    assign r_fire   = rvalid & rready;
    assign beat_err = (rdata != pat_full) | (rlast != k_last);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (go) state_nx = S_AW;
            S_AW: begin
                if (wd_hit)                 state_nx = S_DONE;
                else if (awvalid & awready) state_nx = S_W;
            end
            S_W: begin
                if (wd_hit)                          state_nx = S_DONE;
                else if (wvalid & wready & k_last)   state_nx = S_B;
            end
            S_B: begin
                if (wd_hit)      state_nx = S_DONE;
                else if (bvalid) state_nx = S_AR;
            end
            S_AR: begin
                if (wd_hit)                 state_nx = S_DONE;
                else if (arvalid & arready) state_nx = S_R;
            end
            S_R: begin
                if (wd_hit)                          state_nx = S_DONE;
                else if (r_fire & (rlast | k_last))  state_nx = S_NEXT;
            end
            S_NEXT: state_nx = (({1'b0, bidx} + 17'd1) == NB17) ? S_DONE : S_AW;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn_sync) begin
            state          <= S_IDLE;
            wd_cnt         <= '0;
            bidx           <= '0;
            bbase          <= '0;
            k              <= '0;
            cur_addr       <= '0;
            timeout_r      <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                wd_cnt <= '0;
            else if (wd_cnt != 12'hFFF)
                wd_cnt <= wd_cnt + 12'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        bidx      <= '0;
                        bbase     <= '0;
                        k         <= '0;
                        cur_addr  <= BASE_ADDR;
                        err_cnt   <= '0;
                        timeout_r <= 1'b0;
                    end
                end
                S_AW, S_AR: k <= '0;
                S_W: if (wvalid & wready) k <= k_last ? 9'd0 : k + 9'd1;
                S_R: begin
                    if (r_fire) begin
                        k <= k + 9'd1;
                        if (beat_err) begin
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                            if (err_cnt == 16'd0)    first_err_addr <= cur_addr;
                        end
                    end
                end
                S_NEXT: begin
                    bidx     <= bidx + 16'd1;
                    bbase    <= bbase + BEATS;
                    cur_addr <= cur_addr + ADDR_STEP;
                    k        <= '0;
                end
                default: ;
            endcase

            if (wd_hit) timeout_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_axi_tester.sv
// Scoreboard bench for ddr_axi_tester: behavioural AXI slave with memory, queued expectations, negedge monitor.
module tb_ddr_axi_tester;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam logic [AW-1:0] BASE = 26'h3FFFE80;  // bursts straddle the top of the address space

    logic          core_clk = 1'b0;
    logic          core_rstn_sync = 1'b0;
    logic          init_done = 1'b0;
    logic          start = 1'b0;
    logic          awvalid, awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid, wready = 1'b0;
    logic [DW-1:0] wdata;
    logic          wlast;
    logic          bvalid = 1'b0, bready;
    logic          arvalid, arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid = 1'b0, rready;
    logic [DW-1:0] rdata = '0;
    logic          rlast = 1'b0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    ddr_axi_tester #(.BASE_ADDR(BASE)) dut (
        .core_clk(core_clk), .core_rstn_sync(core_rstn_sync), .init_done(init_done), .start(start),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;
    bit hang = 0, gaps = 0, corrupt = 0;
    int r_cnt = 0;

    logic [AW-1:0] exp_aw[$];
    logic [AW-1:0] exp_ar[$];
    logic [16:0]   exp_w[$];   // {wlast, wdata}

    // Burst addresses A(b) = BASE + b*'h100 mod 2^26, worked out by hand
    logic [AW-1:0] addr_tbl [4] = '{26'h3FFFE80, 26'h3FFFF80, 26'h0000080, 26'h0000180};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit coin();
        return gaps ? bit'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // ---------------- slave model ----------------
    logic [15:0] mem [int];
    logic [AW-1:0] aw_a, ar_a;
    int  wbeat, rbeat;
    bit  wv_prev, b_pend, r_pend;

    always @(negedge core_clk) begin
        if (!core_rstn_sync) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0; rlast = 0;
            wv_prev = 0; b_pend = 0; r_pend = 0; wbeat = 0; rbeat = 0;
        end else begin
            awready = awvalid && !hang && coin();
            if (awvalid && awready) begin aw_a = awaddr; wbeat = 0; end
            wready = wvalid && wv_prev && coin();
            wv_prev = wvalid;
            if (wvalid && wready) begin
                mem[int'(aw_a) + wbeat*2] = wdata;
                wbeat++;
                if (wlast) b_pend = 1;
            end
            bvalid = b_pend && bready && coin();
            if (bvalid) b_pend = 0;
            arready = arvalid && coin();
            if (arvalid && arready) begin ar_a = araddr; rbeat = 0; r_pend = 1; end
            if (r_pend && rready && coin()) begin
                rvalid = 1;
                rdata = mem.exists(int'(ar_a) + rbeat*2) ? mem[int'(ar_a) + rbeat*2] : 16'h0;
                if (corrupt && ar_a == 26'h80 && rbeat == 3) rdata = rdata ^ 16'h1;
                rlast = (rbeat == 7);
                rbeat++;
                if (rlast) r_pend = 0;
            end else begin
                rvalid = 0; rlast = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    bit w_wait = 0;
    logic [16:0] w_prev;

    always @(negedge core_clk) begin
        #1;
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) begin
                checks++; errors++; $display("FAIL aw_unexpected actual=%0h required=none", awaddr);
            end else begin
                chk("awaddr", awaddr, exp_aw.pop_front());
                chk("awlen", awlen, 8'd7);
            end
        end
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) begin
                checks++; errors++; $display("FAIL ar_unexpected actual=%0h required=none", araddr);
            end else begin
                chk("araddr", araddr, exp_ar.pop_front());
                chk("arlen", arlen, 8'd7);
            end
        end
        if (wvalid) begin
            if (w_wait) chk("w_stable", {wlast, wdata}, w_prev);
            w_prev = {wlast, wdata};
            w_wait = !wready;
            if (wready) begin
                if (exp_w.size() == 0) begin
                    checks++; errors++; $display("FAIL w_unexpected actual=%0h required=none", wdata);
                end else begin
                    chk("wbeat", {wlast, wdata}, exp_w.pop_front());
                end
            end
        end else begin
            w_wait = 0;
        end
        if (rvalid && rready) r_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic push_run();
        for (int b = 0; b < 4; b++) begin
            exp_aw.push_back(addr_tbl[b]);
            exp_ar.push_back(addr_tbl[b]);
            for (int k = 0; k < 8; k++)
                exp_w.push_back({(k == 7), 16'(b*8 + k) ^ 16'hA5C3});
        end
    endtask

    task automatic pulse_start();
        @(negedge core_clk) start = 1;
        @(negedge core_clk) start = 0;
    endtask

    task automatic wait_done(input int bound, output int awv_cycles);
        int n;
        awv_cycles = 0;
        for (n = 0; n < bound; n++) begin
            if (done) break;
            if (awvalid) awv_cycles++;
            @(negedge core_clk);
        end
        if (n == bound) begin
            checks++; errors++;
            $display("FAIL done_wait actual=no_done required=done_within_%0d", bound);
        end
    endtask

    task automatic normal_run(input string tag, input logic exp_pass, input logic [15:0] exp_err);
        int awc;
        r_cnt = 0;
        push_run();
        pulse_start();
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(20000, awc);
        repeat (2) @(negedge core_clk);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_pass"}, pass, exp_pass);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_w_left"}, exp_w.size(), 0);
        chk({tag, "_aw_left"}, exp_aw.size(), 0);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
        chk({tag, "_r_beats"}, r_cnt, 32);
    endtask

    initial begin
        int awc, n;
        repeat (3) @(negedge core_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        chk("rst_first_err", first_err_addr, 26'd0);
        core_rstn_sync = 1;

        // start ignored while init is incomplete
        pulse_start();
        repeat (3) @(negedge core_clk);
        chk("noinit_busy", busy, 1'b0);
        chk("noinit_awvalid", awvalid, 1'b0);
        chk("noinit_done", done, 1'b0);
        init_done = 1;

        normal_run("ideal", 1'b1, 16'd0);

        corrupt = 1;
        normal_run("corrupt", 1'b0, 16'd1);
        chk("corrupt_first_err", first_err_addr, 26'h0000080);
        corrupt = 0;

        gaps = 1;
        normal_run("gaps", 1'b1, 16'd0);
        gaps = 0;

        // slave never accepts the write address
        hang = 1;
        pulse_start();
        wait_done(6000, awc);
        chk("hang_awvalid_cycles", awc, 4095);
        chk("hang_done", done, 1'b1);
        chk("hang_timeout", timeout, 1'b1);
        chk("hang_pass", pass, 1'b0);
        chk("hang_awvalid", awvalid, 1'b0);
        chk("hang_busy", busy, 1'b0);
        hang = 0;
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();

        // reset while write data is in flight
        push_run();
        pulse_start();
        for (n = 0; n < 200; n++) begin
            if (wvalid) break;
            @(negedge core_clk);
        end
        chk("midw_reached_w", wvalid, 1'b1);
        core_rstn_sync = 0;
        @(negedge core_clk);
        chk("midw_rst_outs", {awvalid, wvalid, arvalid, bready, rready, busy, done, pass, timeout}, 9'd0);
        chk("midw_rst_wdata", {wlast, wdata, awlen, arlen}, 33'd0);
        chk("midw_rst_err", err_cnt, 16'd0);
        chk("midw_rst_addr", {awaddr, araddr, first_err_addr}, 78'd0);
        core_rstn_sync = 1;
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();
        repeat (3) @(negedge core_clk);
        chk("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
